// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - registered execute stage: logic/add/sub/slt in one cycle, iterative 32-step multiply
module alu_exec_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_SLT  = 3'b110;
    localparam logic [2:0] OP_MULT = 3'b111;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_overflow;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [4:0]       r_count;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_bneg;
    logic [WIDTH-1:0] w_diff;
    logic             w_slt;
    logic [WIDTH-1:0] w_alu_result;
    logic             w_alu_ovf;
    logic [WIDTH-1:0] w_mul_sum;

    assign w_sum  = input1 + input2;
    assign w_bneg = ~input2 + WIDTH'(1);
    assign w_diff = input1 + w_bneg;
    // Direct signed compare stays correct when input1 - input2 overflows.
    assign w_slt  = $signed(input1) < $signed(input2);

    always_comb begin
        w_alu_result = '0;
        w_alu_ovf    = 1'b0;
        case (op)
            OP_AND: w_alu_result = input1 & input2;
            OP_OR:  w_alu_result = input1 | input2;
            OP_XOR: w_alu_result = input1 ^ input2;
            OP_NOR: w_alu_result = ~(input1 | input2);
            OP_ADD: begin
                w_alu_result = w_sum;
                w_alu_ovf    = (input1[WIDTH-1] == input2[WIDTH-1]) &&
                               (w_sum[WIDTH-1] != input1[WIDTH-1]);
            end
            OP_SUB: begin
                w_alu_result = w_diff;
                w_alu_ovf    = (input1[WIDTH-1] == w_bneg[WIDTH-1]) &&
                               (w_diff[WIDTH-1] != input1[WIDTH-1]);
            end
            OP_SLT: w_alu_result = {{(WIDTH-1){1'b0}}, w_slt};
            default: w_alu_result = '0;
        endcase
    end

    assign w_mul_sum = r_acc + (r_mplier[r_count] ? (r_mcand << r_count) : '0);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_next_state = (op == OP_MULT) ? S_MUL : S_DONE;
            S_MUL:  if (r_count == 5'd31) w_next_state = S_DONE;
            S_DONE: if (out_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_result   <= '0;
            r_zero     <= 1'b1;
            r_overflow <= 1'b0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_acc      <= '0;
            r_count    <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (op == OP_MULT) begin
                            r_mcand  <= input1;
                            r_mplier <= input2;
                            r_acc    <= '0;
                            r_count  <= '0;
                        end else begin
                            r_result   <= w_alu_result;
                            r_zero     <= (w_alu_result == '0);
                            r_overflow <= w_alu_ovf;
                        end
                    end
                end
                S_MUL: begin
                    r_acc   <= w_mul_sum;
                    r_count <= r_count + 5'd1;
                    if (r_count == 5'd31) begin
                        r_result   <= w_mul_sum;
                        r_zero     <= (w_mul_sum == '0);
                        r_overflow <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE) && reset_n;
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign zero      = r_zero;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - directed self-checking bench for alu_exec_stage
module tb_alu_exec_stage;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'b000;
    logic [31:0] input1 = '0;
    logic [31:0] input2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;
    logic        overflow;

    int checks = 0;
    int failures = 0;

    alu_exec_stage #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .input1    (input1),
        .input2    (input2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one op, scramble inputs after accept, check latency, outputs, then consume.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input logic exp_zero, input logic exp_ovf,
                          input int exp_lat, input logic consume);
        int n;
        logic ready_seen;
        @(negedge clk);
        in_valid = 1'b1;
        op       = o;
        input1   = a;
        input2   = b;
        check_eq({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        op         = ~o;
        input1     = ~a;
        input2     = $urandom;
        n          = 0;
        ready_seen = 1'b0;
        while (!out_valid && n < 100) begin
            if (in_ready) ready_seen = 1'b1;
            input1 = $urandom;
            @(posedge clk);
            #1;
            n++;
        end
        check_eq({tag, "_latency"}, n, exp_lat);
        check_eq({tag, "_busy_ready"}, {31'd0, ready_seen}, 32'd0);
        check_eq({tag, "_result"}, result, exp_res);
        check_eq({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_zero});
        check_eq({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
        if (consume) begin
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            check_eq({tag, "_drop"}, {31'd0, out_valid}, 32'd0);
        end
    endtask

    initial begin
        int  n;
        logic seen;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_result", result, 32'd0);
        check_eq("rst_zero", {31'd0, zero}, 32'd1);
        check_eq("rst_ovf", {31'd0, overflow}, 32'd0);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run_op("xor", 3'b010, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0, 1'b0, 0, 1'b1);
        run_op("and", 3'b000, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000, 1'b0, 1'b0, 0, 1'b1);
        run_op("or",  3'b001, 32'hFFFF0000, 32'h0F0F0F0F, 32'hFFFF0F0F, 1'b0, 1'b0, 0, 1'b1);
        run_op("nor", 3'b011, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0000F0F0, 1'b0, 1'b0, 0, 1'b1);
        run_op("add_ovf", 3'b100, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 0, 1'b1);
        run_op("sub_zero", 3'b101, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 0, 1'b1);
        run_op("sub_ovf", 3'b101, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 0, 1'b1);
        run_op("slt_neg", 3'b110, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 0, 1'b1);
        run_op("slt_max", 3'b110, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 0, 1'b1);
        run_op("slt_min", 3'b110, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 0, 1'b1);
        run_op("mul_a", 3'b111, 32'h00010001, 32'h00010001, 32'h00020001, 1'b0, 1'b0, 32, 1'b1);
        run_op("mul_b", 3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32, 1'b1);
        run_op("mul_c", 3'b111, 32'h00001234, 32'h00000010, 32'h00012340, 1'b0, 1'b0, 32, 1'b0);

        // Backpressure: DONE held with out_ready low.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check_eq("bp_result", result, 32'h00012340);
            check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check_eq("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end

        // Back-to-back: in_valid already high when out_ready rises.
        @(negedge clk);
        in_valid  = 1'b1;
        op        = 3'b100;
        input1    = 32'd10;
        input2    = 32'd20;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("b2b_idle_valid", {31'd0, out_valid}, 32'd0);
        check_eq("b2b_idle_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq("b2b_accept_valid", {31'd0, out_valid}, 32'd1);
        check_eq("b2b_result", result, 32'd30);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset in the middle of a MULT.
        @(negedge clk);
        in_valid = 1'b1;
        op       = 3'b111;
        input1   = 32'h00000003;
        input2   = 32'h00000005;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("abort_result", result, 32'd0);
        check_eq("abort_zero", {31'd0, zero}, 32'd1);
        check_eq("abort_ovf", {31'd0, overflow}, 32'd0);
        check_eq("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("abort_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        for (n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check_eq("abort_no_valid", {31'd0, seen}, 32'd0);

        run_op("add_after", 3'b100, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
